// File: rtl/rc4_engine.sv
// rc4_engine: RC4 sequencer covering S-box initialisation, key scheduling
// and keystream generation against an external single-port S-box RAM,
// an encrypted-message ROM and a decrypted-message RAM.
// All memories have a registered address: read data is consumed two
// cycles after the address is first driven.
// Build option: define RC4_PRGA_EN to compile in the keystream/decrypt
// phase; without it the run ends after key scheduling and the message
// ports are tied to zero.
// Handshake: start is a level sampled only in IDLE; busy is high for the
// whole run; done is a one-cycle pulse after which the core is IDLE again.
module rc4_engine #(
    parameter int KEY_BYTES = 3,
    parameter int MSG_LEN   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rdata,
    output logic [7:0]             m_addr,
    input  logic [7:0]             m_rdata,
    output logic [7:0]             d_addr,
    output logic [7:0]             d_wdata,
    output logic                   d_wren
);

    typedef enum logic [4:0] {
        IDLE, INIT,
        K_RD_I, K_LAT_I, K_RD_J, K_LAT_J, K_WR_I, K_WR_J,
        P_RD_I, P_LAT_I, P_RD_J, P_LAT_J, P_WR_I, P_WR_J,
        P_RD_F, P_LAT_F, P_OUT,
        DONE
    } state_t;

    localparam logic [4:0] LAST_KI = 5'(KEY_BYTES - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [8*KEY_BYTES-1:0] r_key;
    logic [7:0]             r_i;
    logic [7:0]             r_j;
    logic [4:0]             r_ki;
    logic [7:0]             r_si;
    logic [7:0]             w_key_byte;
    logic [7:0]             w_ksa_j;

    // Last driven address/data, held between the states that drive them
    logic [7:0]             r_s_addr;
    logic [7:0]             r_s_wdata;
    logic [7:0]             w_s_addr;
    logic [7:0]             w_s_wdata;
    logic                   w_s_wren;

`ifdef RC4_PRGA_EN
    localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

    logic [7:0]             r_k;
    logic [7:0]             r_sj;
    logic [7:0]             r_m_addr;
    logic [7:0]             r_d_addr;
    logic [7:0]             r_d_wdata;
    logic [7:0]             w_m_addr;
    logic [7:0]             w_d_addr;
    logic [7:0]             w_d_wdata;
    logic                   w_d_wren;
    logic [7:0]             w_prga_j;
`else
    logic                   w_unused_m_rdata;
`endif

    // Key byte 0 is the most significant byte of the key bus
    always_comb begin
        w_key_byte = 8'(r_key >> (8 * (KEY_BYTES - 1 - int'(r_ki))));
        w_ksa_j    = r_j + s_rdata + w_key_byte;
    end

`ifdef RC4_PRGA_EN
    assign w_prga_j = r_j + s_rdata;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; each KSA/PRGA step is a fixed chain of states
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = INIT;
            INIT:    if (r_i == 8'hFF) w_next = K_RD_I;
            K_RD_I:  w_next = K_LAT_I;
            K_LAT_I: w_next = K_RD_J;
            K_RD_J:  w_next = K_LAT_J;
            K_LAT_J: w_next = K_WR_I;
            K_WR_I:  w_next = K_WR_J;
`ifdef RC4_PRGA_EN
            K_WR_J:  w_next = (r_i == 8'hFF) ? P_RD_I : K_RD_I;
            P_RD_I:  w_next = P_LAT_I;
            P_LAT_I: w_next = P_RD_J;
            P_RD_J:  w_next = P_LAT_J;
            P_LAT_J: w_next = P_WR_I;
            P_WR_I:  w_next = P_WR_J;
            P_WR_J:  w_next = P_RD_F;
            P_RD_F:  w_next = P_LAT_F;
            P_LAT_F: w_next = P_OUT;
            P_OUT:   w_next = (r_k == LAST_K) ? DONE : P_RD_I;
`else
            K_WR_J:  w_next = (r_i == 8'hFF) ? DONE : K_RD_I;
`endif
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: indices, key latch and the two swap operands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key  <= '0;
            r_i    <= 8'd0;
            r_j    <= 8'd0;
            r_ki   <= 5'd0;
            r_si   <= 8'd0;
`ifdef RC4_PRGA_EN
            r_k    <= 8'd0;
            r_sj   <= 8'd0;
`endif
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_key <= key;
                    r_i   <= 8'd0;
                    r_j   <= 8'd0;
                    r_ki  <= 5'd0;
`ifdef RC4_PRGA_EN
                    r_k   <= 8'd0;
`endif
                end
                // i wraps 255 -> 0, which is the clear before KSA
                INIT: r_i <= r_i + 8'd1;
                K_RD_J: begin
                    r_si <= s_rdata;
                    r_j  <= w_ksa_j;
                end
                K_WR_J: begin
                    r_i  <= r_i + 8'd1;
                    r_ki <= (r_ki == LAST_KI) ? 5'd0 : r_ki + 5'd1;
                    if (r_i == 8'hFF) r_j <= 8'd0;
                end
`ifdef RC4_PRGA_EN
                P_RD_I: r_i <= r_i + 8'd1;
                P_RD_J: begin
                    r_si <= s_rdata;
                    r_j  <= w_prga_j;
                end
                P_WR_I: r_sj <= s_rdata;
                P_OUT:  r_k  <= r_k + 8'd1;
`endif
                default: ;
            endcase
        end
    end

    // Output logic; addresses/data default to their held value, only the
    // write enables are qualified by state
    always_comb begin
        w_s_addr  = r_s_addr;
        w_s_wdata = r_s_wdata;
        w_s_wren  = 1'b0;
`ifdef RC4_PRGA_EN
        w_m_addr  = r_m_addr;
        w_d_addr  = r_d_addr;
        w_d_wdata = r_d_wdata;
        w_d_wren  = 1'b0;
`endif
        case (r_state)
            INIT: begin
                w_s_addr  = r_i;
                w_s_wdata = r_i;
                w_s_wren  = 1'b1;
            end
            K_RD_I: w_s_addr = r_i;
            K_RD_J: w_s_addr = w_ksa_j;
            // sj is written straight from the read bus in the cycle it lands
            K_WR_I: begin
                w_s_addr  = r_i;
                w_s_wdata = s_rdata;
                w_s_wren  = 1'b1;
            end
            K_WR_J: begin
                w_s_addr  = r_j;
                w_s_wdata = r_si;
                w_s_wren  = 1'b1;
            end
`ifdef RC4_PRGA_EN
            P_RD_I: w_s_addr = r_i + 8'd1;
            P_RD_J: w_s_addr = w_prga_j;
            P_WR_I: begin
                w_s_addr  = r_i;
                w_s_wdata = s_rdata;
                w_s_wren  = 1'b1;
            end
            P_WR_J: begin
                w_s_addr  = r_j;
                w_s_wdata = r_si;
                w_s_wren  = 1'b1;
            end
            P_RD_F: begin
                w_s_addr = r_si + r_sj;
                w_m_addr = r_k;
            end
            P_OUT: begin
                w_d_addr  = r_k;
                w_d_wdata = s_rdata ^ m_rdata;
                w_d_wren  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Hold registers for the last driven address/data values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_addr  <= 8'd0;
            r_s_wdata <= 8'd0;
`ifdef RC4_PRGA_EN
            r_m_addr  <= 8'd0;
            r_d_addr  <= 8'd0;
            r_d_wdata <= 8'd0;
`endif
        end else begin
            r_s_addr  <= w_s_addr;
            r_s_wdata <= w_s_wdata;
`ifdef RC4_PRGA_EN
            r_m_addr  <= w_m_addr;
            r_d_addr  <= w_d_addr;
            r_d_wdata <= w_d_wdata;
`endif
        end
    end

    assign busy    = (r_state != IDLE) && (r_state != DONE);
    assign done    = (r_state == DONE);
    assign s_addr  = w_s_addr;
    assign s_wdata = w_s_wdata;
    assign s_wren  = w_s_wren;
`ifdef RC4_PRGA_EN
    assign m_addr  = w_m_addr;
    assign d_addr  = w_d_addr;
    assign d_wdata = w_d_wdata;
    assign d_wren  = w_d_wren;
`else
    assign m_addr  = 8'd0;
    assign d_addr  = 8'd0;
    assign d_wdata = 8'd0;
    assign d_wren  = 1'b0;
    assign w_unused_m_rdata = ^m_rdata;
`endif

endmodule

// File: tb/tb_rc4_engine.sv
// Directed bench for rc4_engine. Instance A: KEY_BYTES=3, MSG_LEN=9.
// Instance B: KEY_BYTES=4, MSG_LEN=5. Cycle n is sampled on the falling
// edge after rising edge n-1; start is accepted at edge 0.
module tb_rc4_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int total = 0;
  int bad = 0;

  // instance A signals and memories
  logic a_start, a_busy, a_done, a_s_wren, a_d_wren;
  logic [23:0] a_key;
  logic [7:0] a_s_addr, a_s_wdata, a_m_addr, a_d_addr, a_d_wdata;
  logic [7:0] a_s_rdata = 8'd0;
  logic [7:0] a_m_rdata = 8'd0;
  logic [7:0] a_s_aq = 8'd0;
  logic [7:0] a_m_aq = 8'd0;
  logic [7:0] sbox_a [256];
  logic [7:0] rom_a [256];
  logic [7:0] dram_a [256];

  // instance B signals and memories
  logic b_start, b_busy, b_done, b_s_wren, b_d_wren;
  logic [31:0] b_key;
  logic [7:0] b_s_addr, b_s_wdata, b_m_addr, b_d_addr, b_d_wdata;
  logic [7:0] b_s_rdata = 8'd0;
  logic [7:0] b_m_rdata = 8'd0;
  logic [7:0] b_s_aq = 8'd0;
  logic [7:0] b_m_aq = 8'd0;
  logic [7:0] sbox_b [256];
  logic [7:0] rom_b [256];
  logic [7:0] dram_b [256];

  // run monitor results
  int init_ok, first_wr, dwr_cnt, busy_ok, dcyc, n;

  rc4_engine #(.KEY_BYTES(3), .MSG_LEN(9)) u_dut_a (
    .clk(clk), .reset(reset), .start(a_start), .key(a_key),
    .busy(a_busy), .done(a_done),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wren(a_s_wren), .s_rdata(a_s_rdata),
    .m_addr(a_m_addr), .m_rdata(a_m_rdata),
    .d_addr(a_d_addr), .d_wdata(a_d_wdata), .d_wren(a_d_wren)
  );

  rc4_engine #(.KEY_BYTES(4), .MSG_LEN(5)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .key(b_key),
    .busy(b_busy), .done(b_done),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wren(b_s_wren), .s_rdata(b_s_rdata),
    .m_addr(b_m_addr), .m_rdata(b_m_rdata),
    .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_wren(b_d_wren)
  );

  // memory models: registered address, data one cycle later
  always @(posedge clk) begin
    if (a_s_wren === 1'b1) sbox_a[a_s_addr] <= a_s_wdata;
    a_s_aq <= a_s_addr;
    a_s_rdata <= sbox_a[a_s_aq];
    a_m_aq <= a_m_addr;
    a_m_rdata <= rom_a[a_m_aq];
    if (a_d_wren === 1'b1) dram_a[a_d_addr] <= a_d_wdata;
    if (b_s_wren === 1'b1) sbox_b[b_s_addr] <= b_s_wdata;
    b_s_aq <= b_s_addr;
    b_s_rdata <= sbox_b[b_s_aq];
    b_m_aq <= b_m_addr;
    b_m_rdata <= rom_b[b_m_aq];
    if (b_d_wren === 1'b1) dram_b[b_d_addr] <= b_d_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Start instance A at cycle 0 (call on a falling edge) and monitor until done
  task automatic run_a(input bit hold);
    int cnt;
    cnt = 0;
    dcyc = -1;
    init_ok = 1;
    first_wr = -1;
    dwr_cnt = 0;
    busy_ok = 1;
    a_start = 1'b1;
    while (cnt < 4000 && dcyc < 0) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1 && !hold) a_start = 1'b0;
      if (cnt <= 256) begin
        if (!(a_s_wren === 1'b1 && a_s_addr === 8'(cnt - 1) && a_s_wdata === 8'(cnt - 1)))
          init_ok = 0;
      end else if (a_s_wren === 1'b1 && first_wr < 0) begin
        first_wr = cnt;
      end
      if (a_d_wren === 1'b1) dwr_cnt++;
      if (a_done === 1'b1) begin
        dcyc = cnt;
        if (a_busy !== 1'b0) busy_ok = 0;
      end else if (a_busy !== 1'b1) begin
        busy_ok = 0;
      end
    end
  endtask

  logic [7:0] exp_pt [9];
  logic [7:0] exp_wiki [5];
  logic [7:0] ref_s [256];
  logic [7:0] kb [3];
  logic seen [256];

  initial begin
    exp_pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    exp_wiki = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = 8'h00;
      rom_b[i] = 8'h00;
      dram_a[i] = 8'h00;
      dram_b[i] = 8'h00;
      sbox_a[i] = 8'h00;
      sbox_b[i] = 8'h00;
    end
    rom_a[0] = 8'hBB; rom_a[1] = 8'hF3; rom_a[2] = 8'h16; rom_a[3] = 8'hE8;
    rom_a[4] = 8'hD9; rom_a[5] = 8'h40; rom_a[6] = 8'hAF; rom_a[7] = 8'h0A;
    rom_a[8] = 8'hD3;
    rom_b[0] = 8'h10; rom_b[1] = 8'h21; rom_b[2] = 8'hBF; rom_b[3] = 8'h04;
    rom_b[4] = 8'h20;
`ifdef RC4_PRGA_EN
    a_key = 24'h4B6579;
`else
    a_key = 24'h00033C;
`endif
    b_key = 32'h57696B69;
    a_start = 1'b0;
    b_start = 1'b0;

    // clock/reset
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs_a", 64'({a_busy, a_done, a_s_wren, a_d_wren, a_s_addr, a_s_wdata,
                               a_m_addr, a_d_addr, a_d_wdata}), 64'd0);
    check("reset_outs_b", 64'({b_busy, b_done, b_s_wren, b_d_wren, b_s_addr, b_s_wdata,
                               b_m_addr, b_d_addr, b_d_wdata}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outs_a", 64'({a_busy, a_done, a_s_wren, a_d_wren, a_s_addr}), 64'd0);

    // reset pulsed mid-KSA at cycle 700
    a_start = 1'b1;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (c == 1) a_start = 1'b0;
    end
    check("busy_before_reset", 64'(a_busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_outs", 64'({a_busy, a_done, a_s_wren, a_d_wren, a_s_addr, a_s_wdata,
                                 a_m_addr, a_d_addr, a_d_wdata}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_idle", 64'({a_busy, a_done, a_s_wren}), 64'd0);

    // full run after reset
    run_a(1'b0);
    check("init_sequence", 64'(init_ok), 64'd1);
    check("first_ksa_write_cycle", 64'(first_wr), 64'd261);
    check("busy_window", 64'(busy_ok), 64'd1);
    @(negedge clk);
    check("done_one_pulse", 64'({a_done, a_busy}), 64'd0);

`ifdef RC4_PRGA_EN
    check("done_cycle_key", 64'(dcyc), 64'd1874);
    check("d_wren_count", 64'(dwr_cnt), 64'd9);
    for (int i = 0; i < 9; i++)
      check($sformatf("plaintext_byte%0d", i), 64'(dram_a[i]), 64'(exp_pt[i]));

    // start held high: one run per IDLE visit, next run the cycle after DONE
    for (int i = 0; i < 9; i++) dram_a[i] = 8'h00;
    run_a(1'b1);
    check("held_done_cycle", 64'(dcyc), 64'd1874);
    @(negedge clk);
    check("held_idle_gap", 64'({a_busy, a_done}), 64'd0);
    @(negedge clk);
    check("held_second_start", 64'({a_busy, a_s_wren, a_s_addr}), 64'h200 | 64'h100);
    a_start = 1'b0;
    n = -1;
    for (int c = 1; c <= 4000 && n < 0; c++) begin
      @(negedge clk);
      if (a_done === 1'b1) n = c;
    end
    check("held_second_done", 64'(n), 64'd1873);
    repeat (3) @(negedge clk);
    check("no_third_run", 64'(a_busy), 64'd0);
    for (int i = 0; i < 9; i++)
      check($sformatf("held_plaintext_byte%0d", i), 64'(dram_a[i]), 64'(exp_pt[i]));

    // instance B: "Wiki" / "pedia"
    b_start = 1'b1;
    n = -1;
    for (int c = 1; c <= 4000 && n < 0; c++) begin
      @(negedge clk);
      if (c == 1) b_start = 1'b0;
      if (b_done === 1'b1) n = c;
    end
    check("done_cycle_wiki", 64'(n), 64'd1838);
    for (int i = 0; i < 5; i++)
      check($sformatf("pedia_byte%0d", i), 64'(dram_b[i]), 64'(exp_wiki[i]));
`else
    check("done_cycle_ksa_only", 64'(dcyc), 64'd1793);
    check("d_wren_count", 64'(dwr_cnt), 64'd0);
    // reference key schedule for key 00 03 3C
    kb = '{8'h00, 8'h03, 8'h3C};
    for (int i = 0; i < 256; i++) ref_s[i] = 8'(i);
    begin
      logic [7:0] jj;
      logic [7:0] tmp;
      int mism;
      int distinct;
      jj = 8'd0;
      for (int i = 0; i < 256; i++) begin
        jj = jj + ref_s[i] + kb[i % 3];
        tmp = ref_s[i];
        ref_s[i] = ref_s[jj];
        ref_s[jj] = tmp;
      end
      mism = 0;
      for (int i = 0; i < 256; i++) begin
        if (sbox_a[i] !== ref_s[i]) mism++;
        seen[i] = 1'b0;
      end
      check("sbox_vs_reference_mismatches", 64'(mism), 64'd0);
      for (int i = 0; i < 256; i++)
        if (!$isunknown(sbox_a[i])) seen[sbox_a[i]] = 1'b1;
      distinct = 0;
      for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
      check("sbox_permutation", 64'(distinct), 64'd256);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
